// File: rtl/rename_if.sv
// rename_if: decode-side, dispatch-side and release signals of the rename stage.
// Ports (signals):
//   in_*        decode -> rename instruction with valid/ready handshake
//   out_*       rename -> reservation stations, registered, valid/ready
//   free_*      ROB commit releasing a physical tag to the free list
//   free_count  number of tags currently in the free list
//   err_overflow sticky flag: a release arrived while the free list was full
// Optional (RENAME_RECOVERY_EN): commit_valid/commit_rd/commit_pd/commit_alloc
//   carry retirement updates; flush rolls speculative state back.
// Modports: master = decode/ROB side, slave = rename unit.
interface rename_if #(
  parameter int PREG_W  = 6,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         in_opcode;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic [4:0]         in_rd;
  logic               in_writes_rd;
  logic [INSTR_W-1:0] in_instr;

  logic               out_valid;
  logic               out_ready;
  logic [6:0]         out_opcode;
  logic [PREG_W-1:0]  out_ps1;
  logic [PREG_W-1:0]  out_ps2;
  logic [PREG_W-1:0]  out_pd;
  logic [PREG_W-1:0]  out_old_pd;
  logic [INSTR_W-1:0] out_instr;

  logic               free_valid;
  logic [PREG_W-1:0]  free_preg;
  logic [PREG_W:0]    free_count;
  logic               err_overflow;

`ifdef RENAME_RECOVERY_EN
  logic               commit_valid;
  logic [4:0]         commit_rd;
  logic [PREG_W-1:0]  commit_pd;
  logic               commit_alloc;
  logic               flush;
`endif

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_writes_rd, in_instr,
    input  in_ready,
    input  out_valid, out_opcode, out_ps1, out_ps2, out_pd, out_old_pd, out_instr,
    output out_ready,
    output free_valid, free_preg,
    input  free_count, err_overflow
`ifdef RENAME_RECOVERY_EN
    , output commit_valid, commit_rd, commit_pd, commit_alloc, flush
`endif
  );

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_writes_rd, in_instr,
    output in_ready,
    output out_valid, out_opcode, out_ps1, out_ps2, out_pd, out_old_pd, out_instr,
    input  out_ready,
    input  free_valid, free_preg,
    output free_count, err_overflow
`ifdef RENAME_RECOVERY_EN
    , input commit_valid, commit_rd, commit_pd, commit_alloc, flush
`endif
  );
endinterface

// File: rtl/rename_unit.sv
// rename_unit: register-rename stage between decode and the reservation stations.
// Each accepted instruction reads rs1/rs2 through the RAT, and when it writes a
// non-x0 rd it pops a physical tag from a circular free-list FIFO, remaps rd and
// reports the stale mapping (out_old_pd) for release at commit.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        rename_if.slave (decode handshake, output register, release port,
//              free_count, err_overflow)
// Parameters: NUM_ARCH architectural regs, NUM_PHYS physical regs (power of two,
//   greater than NUM_ARCH), INSTR_W passthrough width. PREG_W is derived.
// Optional feature macro: RENAME_RECOVERY_EN adds a retirement RAT and a committed
//   free-list head so a flush can restore the non-speculative state.
module rename_unit #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int INSTR_W  = 32
) (
  input logic     clk,
  input logic     rst,
  rename_if.slave bus
);
  localparam int PREG_W    = $clog2(NUM_PHYS);
  localparam int FREE_INIT = NUM_PHYS - NUM_ARCH;
  localparam logic [PREG_W:0]   FULL_CNT = (PREG_W+1)'(NUM_PHYS);
  localparam logic [PREG_W:0]   CNT_ONE  = (PREG_W+1)'(1);
  localparam logic [PREG_W-1:0] PTR_ONE  = PREG_W'(1);

  logic [PREG_W-1:0]  rat [NUM_ARCH];
  logic [PREG_W-1:0]  fl  [NUM_PHYS];
  logic [PREG_W-1:0]  head, tail, tail_next;
  logic [PREG_W:0]    count;
  logic               err_q;

  logic               out_valid_q;
  logic [6:0]         out_opcode_q;
  logic [PREG_W-1:0]  out_ps1_q, out_ps2_q, out_pd_q, out_old_pd_q;
  logic [INSTR_W-1:0] out_instr_q;

  logic alloc_needed, in_ready_c, accept, do_alloc;
  logic rel_req, do_push, push_drop, flush_act;

`ifdef RENAME_RECOVERY_EN
  logic [PREG_W-1:0] rrat [NUM_ARCH];
  logic [PREG_W-1:0] chead, chead_next;
  logic              commit_wr;

  assign flush_act  = bus.flush;
  assign commit_wr  = bus.commit_valid && bus.commit_alloc;
  assign chead_next = commit_wr ? chead + PTR_ONE : chead;
`else
  assign flush_act  = 1'b0;
`endif

  assign alloc_needed = bus.in_writes_rd && (bus.in_rd != 5'd0);
  // No bypass: readiness uses the registered count, so a tag released this
  // cycle cannot feed an allocation into an empty list.
  assign in_ready_c   = (!out_valid_q || bus.out_ready) &&
                        (!alloc_needed || (count != '0)) && !flush_act;
  assign accept       = bus.in_valid && in_ready_c;
  assign do_alloc     = accept && alloc_needed;
  assign rel_req      = bus.free_valid && (bus.free_preg != '0);
  assign do_push      = rel_req && (count != FULL_CNT);
  assign push_drop    = rel_req && (count == FULL_CNT);
  assign tail_next    = do_push ? tail + PTR_ONE : tail;

  // RAT, allocation pointer and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= PREG_W'(i);
      head  <= '0;
      count <= (PREG_W+1)'(FREE_INIT);
    end else begin
`ifdef RENAME_RECOVERY_EN
      if (flush_act) begin
        // A commit landing in the flush cycle is folded into the restore.
        for (int i = 0; i < NUM_ARCH; i++)
          rat[i] <= (commit_wr && bus.commit_rd == 5'(i)) ? bus.commit_pd : rrat[i];
        head  <= chead_next;
        count <= {1'b0, tail_next - chead_next};
      end else
`endif
      begin
        if (do_alloc) begin
          rat[bus.in_rd] <= fl[head];
          head           <= head + PTR_ONE;
        end
        case ({do_alloc, do_push})
          2'b10:   count <= count - CNT_ONE;
          2'b01:   count <= count + CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Free-list storage, release pointer and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++)
        fl[i] <= (i < FREE_INIT) ? PREG_W'(NUM_ARCH + i) : '0;
      tail  <= PREG_W'(FREE_INIT);
      err_q <= 1'b0;
    end else begin
      if (do_push) fl[tail] <= bus.free_preg;
      tail <= tail_next;
      if (push_drop) err_q <= 1'b1;
    end
  end

`ifdef RENAME_RECOVERY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rrat[i] <= PREG_W'(i);
      chead <= '0;
    end else begin
      if (commit_wr) rrat[bus.commit_rd] <= bus.commit_pd;
      chead <= chead_next;
    end
  end
`endif

  // Output register: sources read the pre-update RAT, so rd==rs hazards see
  // the old mapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_ps1_q    <= '0;
      out_ps2_q    <= '0;
      out_pd_q     <= '0;
      out_old_pd_q <= '0;
      out_instr_q  <= '0;
    end else if (flush_act) begin
      out_valid_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_opcode_q <= bus.in_opcode;
      out_ps1_q    <= (bus.in_rs1 == 5'd0) ? '0 : rat[bus.in_rs1];
      out_ps2_q    <= (bus.in_rs2 == 5'd0) ? '0 : rat[bus.in_rs2];
      out_pd_q     <= alloc_needed ? fl[head] : '0;
      out_old_pd_q <= alloc_needed ? rat[bus.in_rd] : '0;
      out_instr_q  <= bus.in_instr;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = out_opcode_q;
  assign bus.out_ps1      = out_ps1_q;
  assign bus.out_ps2      = out_ps2_q;
  assign bus.out_pd       = out_pd_q;
  assign bus.out_old_pd   = out_old_pd_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.free_count   = count;
  assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int PW = 6;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_if #(.PREG_W(PW), .INSTR_W(IW)) bus();
  rename_unit #(.NUM_ARCH(NA), .NUM_PHYS(NP), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: RAT as a plain array, free list as a queue.
  int          rat_m [NA];
  int          fl_q [$];
  bit          ov_m, ovalid_m;
  int          ps1_m, ps2_m, pd_m, old_m, opc_m;
  logic [31:0] instr_m;

  typedef struct {
    int rs1, rs2, rd;
    bit wr;
    int ps1, ps2, pd, old, cnt;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) rat_m[i] = i;
    fl_q.delete();
    for (int t = NA; t < NP; t++) fl_q.push_back(t);
    ov_m = 0; ovalid_m = 0;
    ps1_m = 0; ps2_m = 0; pd_m = 0; old_m = 0; opc_m = 0; instr_m = '0;
  endtask

  task automatic drive_idle();
    bus.in_valid = 0; bus.in_opcode = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_rd = '0; bus.in_writes_rd = 0; bus.in_instr = '0;
    bus.out_ready = 1; bus.free_valid = 0; bus.free_preg = '0;
`ifdef RENAME_RECOVERY_EN
    bus.commit_valid = 0; bus.commit_rd = '0; bus.commit_pd = '0;
    bus.commit_alloc = 0; bus.flush = 0;
`endif
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, ovalid_m);
    chk({tag, "_free_count"}, bus.free_count, fl_q.size());
    chk({tag, "_err_overflow"}, bus.err_overflow, ov_m);
    chk({tag, "_ps1"}, bus.out_ps1, ps1_m);
    chk({tag, "_ps2"}, bus.out_ps2, ps2_m);
    chk({tag, "_pd"}, bus.out_pd, pd_m);
    chk({tag, "_old_pd"}, bus.out_old_pd, old_m);
    chk({tag, "_opcode"}, bus.out_opcode, opc_m);
    chk({tag, "_instr"}, bus.out_instr, instr_m);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit v, input int opc, input int rs1, input int rs2,
                       input int rd, input bit wr, input bit ordy,
                       input bit fv, input int fp, output bit acc, output int pd_got);
    bit          alloc, exp_rdy;
    int          pre;
    logic [31:0] ins;
    ins = $urandom;
    bus.in_valid = v; bus.in_opcode = opc[6:0]; bus.in_rs1 = rs1[4:0];
    bus.in_rs2 = rs2[4:0]; bus.in_rd = rd[4:0]; bus.in_writes_rd = wr;
    bus.in_instr = ins; bus.out_ready = ordy;
    bus.free_valid = fv; bus.free_preg = fp[PW-1:0];
    #1;
    alloc   = wr && (rd != 0);
    exp_rdy = (!ovalid_m || ordy) && (!alloc || fl_q.size() != 0);
    chk("in_ready", bus.in_ready, exp_rdy);
    @(posedge clk);
    pre = fl_q.size();
    acc = v && exp_rdy;
    if (acc) begin
      ovalid_m = 1; opc_m = opc & 'h7f; instr_m = ins;
      ps1_m = (rs1 == 0) ? 0 : rat_m[rs1];
      ps2_m = (rs2 == 0) ? 0 : rat_m[rs2];
      if (alloc) begin
        pd_m = fl_q.pop_front();
        old_m = rat_m[rd];
        rat_m[rd] = pd_m;
      end else begin
        pd_m = 0; old_m = 0;
      end
    end else if (ovalid_m && ordy) begin
      ovalid_m = 0;
    end
    if (fv && fp != 0) begin
      if (pre == NP) ov_m = 1;
      else fl_q.push_back(fp);
    end
    #1;
    check_outputs("cyc");
    pd_got = bus.out_pd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    int pdg, saved_pd;

    tbl[0] = '{rs1:1, rs2:2, rd:5, wr:1, ps1:1,  ps2:2,  pd:32, old:5,  cnt:31};
    tbl[1] = '{rs1:5, rs2:0, rd:5, wr:1, ps1:32, ps2:0,  pd:33, old:32, cnt:30};
    tbl[2] = '{rs1:5, rs2:3, rd:7, wr:0, ps1:33, ps2:3,  pd:0,  old:0,  cnt:30};
    tbl[3] = '{rs1:1, rs2:5, rd:0, wr:1, ps1:1,  ps2:33, pd:0,  old:0,  cnt:30};
    tbl[4] = '{rs1:1, rs2:1, rd:1, wr:1, ps1:1,  ps2:1,  pd:34, old:1,  cnt:29};

    drive_idle();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cycle(1, 51, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, 1, 0, 0, acc, pdg);
      chk("tbl_accept", acc, 1);
      chk("tbl_ps1", bus.out_ps1, tbl[i].ps1);
      chk("tbl_ps2", bus.out_ps2, tbl[i].ps2);
      chk("tbl_pd", bus.out_pd, tbl[i].pd);
      chk("tbl_old_pd", bus.out_old_pd, tbl[i].old);
      chk("tbl_free_count", bus.free_count, tbl[i].cnt);
    end

    // Downstream stall: outputs hold, in_ready low.
    cycle(1, 19, 2, 3, 6, 1, 1, 0, 0, acc, saved_pd);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 19, 4, 4, 8, 1, 0, 0, 0, acc, pdg);
      chk("stall_accept", acc, 0);
      chk("stall_pd_hold", pdg, saved_pd);
    end
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, acc, pdg);
    chk("drain_valid", bus.out_valid, 0);

    // Drain the free list completely.
    for (int k = 0; k < 40 && fl_q.size() > 0; k++)
      cycle(1, 51, k % 32, (k + 3) % 32, 1 + (k % 31), 1, 1, 0, 0, acc, pdg);
    cycle(1, 51, 1, 2, 9, 1, 1, 0, 0, acc, pdg);
    chk("empty_accept", acc, 0);
    chk("empty_count", bus.free_count, 0);
    // Release into an empty list: no same-cycle bypass.
    cycle(1, 51, 1, 2, 9, 1, 1, 1, 7, acc, pdg);
    chk("nobypass_accept", acc, 0);
    cycle(1, 51, 1, 2, 9, 1, 1, 0, 0, acc, pdg);
    chk("refill_accept", acc, 1);
    chk("refill_pd", pdg, 7);

    // Fill to capacity, then overflow.
    for (int k = 0; k < 70 && fl_q.size() < NP; k++)
      cycle(0, 0, 0, 0, 0, 0, 1, 1, 1 + (k % 63), acc, pdg);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 9, acc, pdg);
    chk("ovf_flag", bus.err_overflow, 1);
    chk("ovf_count", bus.free_count, NP);
    cycle(1, 51, 0, 0, 10, 1, 1, 0, 0, acc, pdg);
    cycle(1, 51, 0, 0, 11, 1, 1, 1, 12, acc, pdg);
    chk("alloc_rel_count", bus.free_count, NP - 1);
    // Release of tag 0 is ignored.
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, acc, pdg);

    // Randomized traffic against the model, ending in a mid-flight reset.
    do_reset();
    for (int k = 0; k < 400; k++)
      cycle(($urandom % 4) != 0, $urandom_range(0, 127), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom % 2,
            ($urandom % 4) != 0, ($urandom % 4) == 0, $urandom_range(0, 63), acc, pdg);
    do_reset();
    cycle(1, 51, 1, 2, 5, 1, 1, 0, 0, acc, pdg);
    chk("post_reset_pd", pdg, 32);

`ifdef RENAME_RECOVERY_EN
    do_reset();
    cycle(1, 51, 0, 0, 3, 1, 1, 0, 0, acc, pdg);
    chk("rec_first_pd", pdg, 32);
    bus.commit_valid = 1; bus.commit_rd = 5'd3; bus.commit_pd = 6'd32; bus.commit_alloc = 1;
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, acc, pdg);
    bus.commit_valid = 0; bus.commit_alloc = 0;
    cycle(1, 51, 0, 0, 3, 1, 1, 0, 0, acc, pdg);
    chk("rec_second_pd", pdg, 33);
    bus.flush = 1; bus.in_valid = 1; bus.in_writes_rd = 1; bus.in_rd = 5'd4;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_count", bus.free_count, 31);
    @(negedge clk);
    bus.flush = 0; bus.in_valid = 0;
    rat_m[3] = 32; ovalid_m = 0;
    fl_q.delete();
    for (int t = 33; t < NP; t++) fl_q.push_back(t);
    cycle(1, 51, 3, 0, 3, 1, 1, 0, 0, acc, pdg);
    chk("rec_ps1", bus.out_ps1, 32);
    chk("rec_pd", bus.out_pd, 33);
    chk("rec_old_pd", bus.out_old_pd, 32);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Clocked, parametrised register-rename stage between decode and the reservation stations.
- Per accepted instruction: maps rs1/rs2 through the RAT, allocates a physical destination from a circular free-list FIFO, and updates the RAT.
- Returns the stale mapping (old_pd) so the ROB can release it at commit.
- Free-list count is tracked in hardware; valid/ready handshakes on both sides.

Parameters:
- NUM_ARCH, 32, architectural registers; x0 is never renamed.
- NUM_PHYS, 64, physical registers; must be > NUM_ARCH and a power of two.
- PREG_W, $clog2(NUM_PHYS), physical tag width (derived).
- INSTR_W, 32, passthrough instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  rename can accept this cycle
- in_opcode  in  7  opcode
- in_rs1 / in_rs2 / in_rd  in  5 each  architectural source/destination registers
- in_writes_rd  in  1  instruction writes rd
- in_instr  in  INSTR_W  raw instruction
- out_valid  out  1  renamed instruction held
- out_ready  in  1  downstream accepts
- out_opcode  out  7  passthrough
- out_ps1 / out_ps2  out  PREG_W  physical sources
- out_pd  out  PREG_W  allocated destination (0 if none)
- out_old_pd  out  PREG_W  previous mapping of rd
- out_instr  out  INSTR_W  passthrough
- free_valid  in  1  ROB commit releases a tag
- free_preg  in  PREG_W  tag to release
- free_count  out  PREG_W+1  entries in the free list
- err_overflow  out  1  sticky: release attempted while free list full

Behaviour:
- Reset (async, on rst high):
  - RAT[i] = i.
  - Free list holds tags NUM_ARCH..NUM_PHYS-1 in ascending order; head = 0; free_count = NUM_PHYS-NUM_ARCH.
  - All out_* = 0; err_overflow = 0.
- alloc_needed = in_writes_rd && in_rd != 0.
- in_ready = (!out_valid || out_ready) && (!alloc_needed || free_count != 0). in_ready is combinational from state and inputs.
- Accept = in_valid && in_ready. On accept, the output register loads at the next edge (latency 1) and out_valid is set:
  - out_ps1 = RAT[in_rs1], out_ps2 = RAT[in_rs2], using pre-update RAT values.
  - Sources equal to x0 yield 0.
  - If alloc_needed: out_pd = free list head entry, out_old_pd = RAT[in_rd], RAT[in_rd] <= head entry, head advances.
  - Otherwise: out_pd = 0, out_old_pd = 0, no RAT or free-list change.
- If out_valid && out_ready && no accept, out_valid clears. Outputs otherwise hold while out_valid && !out_ready.
- Same-instruction hazard (rd == rs1 or rd == rs2): sources read the old mapping.
- Release: free_valid pushes free_preg at the tail.
  - free_preg == 0 is ignored.
  - Push when free_count == NUM_PHYS is dropped and sets err_overflow.
- Simultaneous allocate and release: both happen; free_count unchanged.
- No bypass: a tag released this cycle cannot satisfy an allocation the same cycle when the list is empty; in_ready stays low.
- Pointers wrap modulo NUM_PHYS.
- Reset mid-operation discards the held instruction and all mappings immediately.

Optional Feature:
- Macro RENAME_RECOVERY_EN.
- When defined, adds:
  - Inputs: commit_valid (1), commit_rd (5), commit_pd (PREG_W), commit_alloc (1), flush (1).
  - A retirement RAT (reset RAT[i] = i) and a committed head pointer.
- commit_valid with commit_alloc: retirement RAT[commit_rd] <= commit_pd, and the committed head advances by 1.
- flush has priority over accept:
  - Next edge: RAT <= retirement RAT, head <= committed head, free_count = tail - committed head, out_valid = 0.
  - in_ready is forced 0 during flush.
  - A free_valid in the same cycle is still pushed.
- When not defined: these ports, the retirement RAT and the committed head do not exist; mappings are never rolled back.

Test Plan:
- Reset, then rename add x5,x1,x2 (writes_rd) -> next cycle out_ps1=1, out_ps2=2, out_pd=32, out_old_pd=5, free_count=31.
- Back-to-back x5 writes, second with rs1=x5 -> second out_ps1=32, out_pd=33, out_old_pd=32.
- Rename 32 writers without release -> 33rd sees in_ready=0, free_count=0; one release of tag 7 -> in_ready=1 next cycle and the writer receives 7.
- Store (writes_rd=0) and rd=x0 writer -> out_pd=0, free_count unchanged; out_ready held low 3 cycles -> outputs stable, in_ready=0.
- Release while free_count=NUM_PHYS -> err_overflow=1, free_count unchanged; simultaneous alloc+release -> count unchanged.
- (RENAME_RECOVERY_EN) Rename x3->32, commit it, rename x3->33, flush -> RAT[x3]=32, next x3 writer gets 33, free_count=31.
